multisim_push_arbiter: RTL



---
 rtl/multisim_push_arbiter_pkg.sv | 17 +
 rtl/multisim_push_arbiter_if.sv | 29 ++
 rtl/multisim_rr_picker.sv | 31 +++
 rtl/multisim_push_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/multisim_push_arbiter_pkg.sv
// Shared types and helpers for the multisim push-side arbiter and schedulers.
package multisim_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  // Widest tag any instance can emit (NUM_REQ is capped at 16).
  localparam int unsigned MaxIdW = 4;
  typedef logic [MaxIdW-1:0] arb_tag_max_t;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multisim_push_arbiter_if.sv
// Requester-side and output-side handshake bundle of the push arbiter.
interface multisim_push_arbiter_if
  import multisim_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64
) ();

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]         req_vld;
  logic [NUM_REQ-1:0]         req_rdy;
  logic [DATA_WIDTH-1:0]      req_data [NUM_REQ];
  logic                       out_vld;
  logic                       out_rdy;
  logic [ID_W+DATA_WIDTH-1:0] out_data;
  logic [ID_W-1:0]            owner_id;

  modport master (
    input  req_vld, req_data, out_rdy,
    output req_rdy, out_vld, out_data, owner_id
  );

  modport slave (
    output req_vld, req_data, out_rdy,
    input  req_rdy, out_vld, out_data, owner_id
  );

endinterface

// File: rtl/multisim_rr_picker.sv
// Combinational round-robin picker: first valid requester strictly after ptr, wrapping.
module multisim_rr_picker #(
  parameter int unsigned NUM   = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NUM-1:0]   vld,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM-1:0]   gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    // k = NUM lands back on ptr itself, so the pointer holder is searched last.
    for (int unsigned k = 1; k <= NUM; k++) begin
      pos = IDX_W'((32'(ptr) + k) % NUM);
      if (!any && vld[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Burst-locking round-robin arbiter merging NUM_REQ streams onto one tagged push channel.
module multisim_push_arbiter
  import multisim_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic                     clk,
  input logic                     rst,
  multisim_push_arbiter_if.master bus
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e                 state_q;
  logic [ID_W-1:0]            owner_q;
  logic [CNT_W-1:0]           burst_q;
  logic                       out_vld_q;
  logic [ID_W+DATA_WIDTH-1:0] out_data_q;

  logic                       load_en;
  logic                       keep_owner;
  logic                       accept;
  logic [ID_W-1:0]            winner;
  logic [NUM_REQ-1:0]         pick_gnt;
  logic [ID_W-1:0]            pick_idx;
  logic                       pick_any;

  multisim_rr_picker #(
    .NUM   (NUM_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .vld (bus.req_vld),
    .ptr (owner_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    load_en    = !out_vld_q || bus.out_rdy;
    keep_owner = (state_q == ARB_OWN) && bus.req_vld[owner_q] &&
                 (burst_q < CNT_W'(MAX_BURST));
    winner     = keep_owner ? owner_q : pick_idx;
    accept     = load_en && (keep_owner || pick_any) && !rst;
    bus.req_rdy = '0;
    if (accept) begin
      bus.req_rdy = keep_owner ? (NUM_REQ'(1) << owner_q) : pick_gnt;
    end
  end

  // Back-pressure freezes everything, so lock release is only judged at load slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= ID_W'(NUM_REQ - 1);
      burst_q    <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (load_en) begin
      if (accept) begin
        state_q    <= ARB_OWN;
        owner_q    <= winner;
        burst_q    <= keep_owner ? burst_q + 1'b1 : CNT_W'(1);
        out_vld_q  <= 1'b1;
        out_data_q <= {winner, bus.req_data[winner]};
      end else begin
        state_q   <= ARB_IDLE;
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.owner_id = owner_q;

endmodule
